// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the CPU/DMA memory-bus arbiter: data width and the
// arbiter state encoding, also used by the DMA engine and CPU memory stage.
package bus_arbiter_pkg;

  localparam int WORD_SIZE = 16;
  localparam int STOLEN_W  = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_CPU = 2'd1,
    GRANT    = 2'd2,
    RELEASE  = 2'd3
  } arb_state_e;

  // The CPU must stay off the bus in every state except IDLE.
  function automatic logic stall_for(input arb_state_e st);
    return st != IDLE;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over count.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q, count_d;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/bus_arbiter.sv
// Hands the memory bus to the DMA engine on request once the CPU is between
// accesses, stalls the CPU while granted, and counts the cycles taken from it.
module bus_arbiter
  import bus_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 BR,
  input  logic                 use_bus,
  input  logic [WORD_SIZE-1:0] dma_address,
  input  logic [WORD_SIZE-1:0] dma_data,
  input  logic                 cpu_mem_busy,
  input  logic                 cpu_read,
  input  logic                 cpu_write,
  input  logic [WORD_SIZE-1:0] cpu_address,
  input  logic [WORD_SIZE-1:0] cpu_data,
  input  logic                 clr_count,
  output logic                 BG,
  output logic                 cpu_stall,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [WORD_SIZE-1:0] mem_address,
  output logic [WORD_SIZE-1:0] mem_data,
  output logic [STOLEN_W-1:0]  stolen_cycles
);

  arb_state_e state_q, state_d;
  logic       bg_q, bg_d;
  logic       stall_q, stall_d;

  // Next state; in WAIT_CPU a dropped request wins over the CPU finishing.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (BR) state_d = cpu_mem_busy ? WAIT_CPU : GRANT;
      end
      WAIT_CPU: begin
        if (!BR)                state_d = IDLE;
        else if (!cpu_mem_busy) state_d = GRANT;
      end
      GRANT: begin
        if (!BR) state_d = RELEASE;
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    bg_d    = (state_d == GRANT);
    stall_d = stall_for(state_d);
  end

  // NOTE: synchronous reset: it is sampled like any other input, so reset only takes effect at an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      bg_q    <= 1'b0;
      stall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bg_q    <= bg_d;
      stall_q <= stall_d;
    end
  end

  assign BG        = bg_q;
  assign cpu_stall = stall_q;

  // Memory port steering; use_bus without a grant is ignored.
  always_comb begin
    mem_read    = cpu_read;
    mem_write   = cpu_write;
    mem_address = cpu_address;
    mem_data    = cpu_data;
    if (bg_q) begin
      mem_read    = 1'b0;
      mem_write   = use_bus;
      mem_address = use_bus ? dma_address : '0;
      mem_data    = use_bus ? dma_data    : '0;
    end
  end

  sat_counter #(.WIDTH(STOLEN_W)) u_stolen (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (clr_count),
    .inc_i   (bg_q),
    .count_o (stolen_cycles)
  );

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: a per-cycle vector table plus hand-written
// sequences for latency, DMA burst, abort, mid-grant reset and saturation.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        BR, use_bus, cpu_mem_busy, cpu_read, cpu_write, clr_count;
  logic [15:0] dma_address, dma_data, cpu_address, cpu_data;
  logic        BG, cpu_stall, mem_read, mem_write;
  logic [15:0] mem_address, mem_data, stolen_cycles;

  int vectors = 0;
  int miscompares = 0;

  bus_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .BR            (BR),
    .use_bus       (use_bus),
    .dma_address   (dma_address),
    .dma_data      (dma_data),
    .cpu_mem_busy  (cpu_mem_busy),
    .cpu_read      (cpu_read),
    .cpu_write     (cpu_write),
    .cpu_address   (cpu_address),
    .cpu_data      (cpu_data),
    .clr_count     (clr_count),
    .BG            (BG),
    .cpu_stall     (cpu_stall),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_data      (mem_data),
    .stolen_cycles (stolen_cycles)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        br, busy, ub, c_rd, c_wr, clr;
    logic [15:0] c_addr, c_data, d_addr, d_data;
    logic        bg, stall, m_rd, m_wr;
    logic [15:0] m_addr, m_data, stolen;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(
    input logic br, busy, ub, c_rd, c_wr, clr,
    input logic [15:0] c_addr, c_data, d_addr, d_data,
    input logic bg, stall, m_rd, m_wr,
    input logic [15:0] m_addr, m_data, stolen);
    vec_t v;
    v.br = br; v.busy = busy; v.ub = ub; v.c_rd = c_rd; v.c_wr = c_wr; v.clr = clr;
    v.c_addr = c_addr; v.c_data = c_data; v.d_addr = d_addr; v.d_data = d_data;
    v.bg = bg; v.stall = stall; v.m_rd = m_rd; v.m_wr = m_wr;
    v.m_addr = m_addr; v.m_data = m_data; v.stolen = stolen;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic idle_inputs();
    BR = 0; use_bus = 0; cpu_mem_busy = 0; cpu_read = 0; cpu_write = 0; clr_count = 0;
    dma_address = '0; dma_data = '0; cpu_address = '0; cpu_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //            br bz ub rd wr clr c_addr    c_data    d_addr    d_data   bg st mrd mwr m_addr    m_data    stolen
    vecs[0]  = mk(0, 0, 0, 0, 1, 0, 16'h0040, 16'h1234, 16'h0000, 16'h0000, 0, 0, 0, 1, 16'h0040, 16'h1234, 16'd0);
    vecs[1]  = mk(0, 0, 0, 1, 0, 0, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 0, 16'h0100, 16'h0000, 16'd0);
    vecs[2]  = mk(0, 0, 1, 1, 0, 0, 16'h0200, 16'h0000, 16'hAAAA, 16'h5A5A, 0, 0, 1, 0, 16'h0200, 16'h0000, 16'd0);
    vecs[3]  = mk(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 1, 0, 0, 16'h0000, 16'h0000, 16'd0);
    vecs[4]  = mk(1, 0, 1, 0, 1, 0, 16'h0777, 16'h7777, 16'h0300, 16'hBEEF, 1, 1, 0, 1, 16'h0300, 16'hBEEF, 16'd1);
    vecs[5]  = mk(0, 0, 0, 0, 1, 0, 16'h0050, 16'h5555, 16'h0000, 16'h0000, 0, 1, 0, 1, 16'h0050, 16'h5555, 16'd2);
    vecs[6]  = mk(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'd2);
    vecs[7]  = mk(0, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'd2);
    vecs[8]  = mk(1, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 1, 0, 0, 16'h0000, 16'h0000, 16'd2);
    vecs[9]  = mk(1, 0, 0, 1, 0, 0, 16'h0123, 16'h0000, 16'h0000, 16'h0000, 1, 1, 0, 0, 16'h0000, 16'h0000, 16'd2);
    vecs[10] = mk(1, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 1, 0, 0, 16'h0000, 16'h0000, 16'd0);
    vecs[11] = mk(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 1, 0, 0, 16'h0000, 16'h0000, 16'd1);
    vecs[12] = mk(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 1, 0, 0, 16'h0000, 16'h0000, 16'd2);
    vecs[13] = mk(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'd2);
    vecs[14] = mk(1, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 1, 0, 0, 16'h0000, 16'h0000, 16'd2);
    vecs[15] = mk(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'd2);

    // Reset state.
    do_reset();
    check("reset_state", {BG, cpu_stall, stolen_cycles}, {1'b0, 1'b0, 16'd0});

    // Per-cycle vector table.
    for (int i = 0; i < 16; i++) begin
      BR = vecs[i].br; cpu_mem_busy = vecs[i].busy; use_bus = vecs[i].ub;
      cpu_read = vecs[i].c_rd; cpu_write = vecs[i].c_wr; clr_count = vecs[i].clr;
      cpu_address = vecs[i].c_addr; cpu_data = vecs[i].c_data;
      dma_address = vecs[i].d_addr; dma_data = vecs[i].d_data;
      step();
      check($sformatf("vec%0d", i),
            {BG, cpu_stall, mem_read, mem_write, mem_address, mem_data, stolen_cycles},
            {vecs[i].bg, vecs[i].stall, vecs[i].m_rd, vecs[i].m_wr,
             vecs[i].m_addr, vecs[i].m_data, vecs[i].stolen});
    end

    // BR high cycles 10..29, CPU idle: BG on 11..30, stall on 11..31, 20 cycles stolen.
    do_reset();
    for (int c = 0; c < 36; c++) begin
      BR = (c >= 10 && c < 30);
      step();
      check($sformatf("lat_idle_c%0d", c + 1), {BG, cpu_stall},
            {((c + 1) >= 11 && (c + 1) <= 30), ((c + 1) >= 11 && (c + 1) <= 31)});
    end
    check("lat_idle_stolen", stolen_cycles, 16'd20);

    // CPU busy cycles 10..14 with BR from 10: stall from 11, BG from 16.
    do_reset();
    for (int c = 0; c < 21; c++) begin
      BR = (c >= 10);
      cpu_mem_busy = (c >= 10 && c <= 14);
      step();
      check($sformatf("lat_busy_c%0d", c + 1), {BG, cpu_stall},
            {((c + 1) >= 16), ((c + 1) >= 11)});
    end

    // DMA burst of 12 words while CPU strobes are held active.
    do_reset();
    BR = 1;
    begin
      int budget = 0;
      while (!BG && budget < 5) begin
        step();
        budget++;
      end
      check("burst_grant_seen", {7'd0, BG}, 8'd1);
    end
    cpu_read = 1; cpu_write = 1; cpu_address = 16'hDEAD; cpu_data = 16'hFFFF;
    for (int k = 0; k < 12; k++) begin
      use_bus = 1;
      dma_address = 16'h01F4 + 16'(k);
      dma_data = 16'(k);
      #1;
      check($sformatf("burst_k%0d", k), {mem_read, mem_write, mem_address, mem_data},
            {1'b0, 1'b1, 16'h01F4 + 16'(k), 16'(k)});
      step();
    end
    use_bus = 0;

    // Reset while granted: BG, stall and count clear after one edge; CPU owns the bus.
    cpu_read = 0;
    reset = 1;
    step();
    check("reset_mid_grant", {BG, cpu_stall, stolen_cycles, mem_write, mem_address},
          {1'b0, 1'b0, 16'd0, 1'b1, 16'hDEAD});
    reset = 0;
    idle_inputs();

    // Abort from WAIT_CPU: BG never rises, state returns to IDLE.
    BR = 1; cpu_mem_busy = 1;
    step();
    check("abort_wait", {BG, cpu_stall}, 2'b01);
    BR = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      check($sformatf("abort_idle%0d", c), {BG, cpu_stall}, 2'b00);
    end
    cpu_mem_busy = 0;
    BR = 1;
    step();
    check("after_abort_regrant", {BG, cpu_stall}, 2'b11);

    // Saturation then clear while still granted.
    do_reset();
    BR = 1;
    repeat (65540) @(posedge clk);
    #1;
    check("sat_hold", {BG, stolen_cycles}, {1'b1, 16'hFFFF});
    step();
    check("sat_hold2", stolen_cycles, 16'hFFFF);
    clr_count = 1;
    step();
    check("sat_clear", {BG, stolen_cycles}, {1'b1, 16'd0});
    clr_count = 0;
    step();
    check("after_clear_inc", stolen_cycles, 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
